port_serial_tx: RTL and testbench

//  Serial transmitter peripheral on the processor's output/input port pair.
//  The CPU writes a byte to out_p0, then toggles bit 0 of out_p1. The block accepts
//  the request and sends the byte as an asynchronous serial frame on tx.
//  It reports busy, pending and a sent-byte count back through in_p0/in_p1.

---
 rtl/port_serial_tx_if.sv | 28 ++
 rtl/port_serial_tx.sv | 144 ++++++++++++++
 tb/tb_port_serial_tx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/port_serial_tx_if.sv
// CPU-side port bundle for the serial transmitter: output ports in, status ports and tx line out.
// Purely wiring. There is no latency and no state in this file.
// There is no backpressure here. The transmitter reports busy and pending status to the CPU via in_p1.
interface port_serial_tx_if;
    logic [7:0] out_p0;   // data byte to transmit
    logic [7:0] out_p1;   // bit0 = go toggle, bits 7:1 ignored
    logic [7:0] in_p0;    // frames-sent counter
    logic [7:0] in_p1;    // bit0 busy, bit1 pending
    logic       tx;       // serial line, idles high

    // CPU / testbench side
    modport master (
        output out_p0,
        output out_p1,
        input  in_p0,
        input  in_p1,
        input  tx
    );

    // Transmitter side
    modport slave (
        input  out_p0,
        input  out_p1,
        output in_p0,
        output in_p1,
        output tx
    );
endinterface

// File: rtl/port_serial_tx.sv
// Async serial transmitter on the CPU port pair. Toggling out_p1[0] sends out_p0 as an 8N1 frame (8E1 with PORT_TX_PARITY_EN).
// tx falls 1 cycle after the toggle is seen. The frame lasts 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
// One request is held pending while a frame is busy and is accepted on the first idle cycle. An even number of toggles cancels itself.
module port_serial_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,   // asynchronous, active-low
    port_serial_tx_if.slave   bus
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PORT_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q;
    logic          tx_q;
    logic          busy_q;
    logic          go_q;
    logic [7:0]    cnt_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_q;
    logic [BW-1:0] baud_q;
`ifdef PORT_TX_PARITY_EN
    logic          parity_q;
`endif

    logic pending;
    logic baud_last;
    logic unused_p1_bits;

    // A request is outstanding whenever the go level differs from the last accepted level
    assign pending        = bus.out_p1[0] ^ go_q;
    assign baud_last      = (baud_q == BAUD_LAST);
    assign unused_p1_bits = ^bus.out_p1[7:1];

    assign bus.tx    = tx_q;
    assign bus.in_p0 = cnt_q;
    assign bus.in_p1 = {6'b0, pending, busy_q};

    // Frame sequencer: every output is registered, and go_q moves only on acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            go_q     <= 1'b0;
            cnt_q    <= 8'd0;
            shift_q  <= 8'd0;
            bit_q    <= 3'd0;
            baud_q   <= '0;
`ifdef PORT_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pending) begin
                        shift_q  <= bus.out_p0;
                        go_q     <= bus.out_p1[0];
                        state_q  <= S_START;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        baud_q   <= '0;
                        bit_q    <= 3'd0;
`ifdef PORT_TX_PARITY_EN
                        parity_q <= ^bus.out_p0;
`endif
                    end
                end

                S_START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q  <= baud_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef PORT_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

`ifdef PORT_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q  <= baud_q + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= cnt_q + 8'd1;
                    end else begin
                        baud_q  <= baud_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_port_serial_tx.sv
// Self-checking bench for port_serial_tx. It uses a bit-level frame model and tracks the sent count.
// Inputs are driven and outputs sampled on the falling clock edge.
// No backpressure applies. The bench models the pending and cancel rules directly.
module tb_port_serial_tx;

`ifdef PORT_TX_PARITY_EN
    localparam int CPB   = 4;
    localparam int NBITS = 11;
`else
    localparam int CPB   = 16;
    localparam int NBITS = 10;
`endif
    localparam int FLEN = CPB * NBITS;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    port_serial_tx_if bus ();

    port_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    logic go_lvl   = 1'b0;
    int   sent     = 0;

    // Frame bit index -> expected line level: start, 8 data LSB first, [even parity], stop
    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef PORT_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Flip the go level; upper bits are random garbage that must be ignored
    task automatic toggle();
        go_lvl     = ~go_lvl;
        bus.out_p1 = {7'($urandom), go_lvl};
    endtask

    // Checks one frame cycle by cycle; request must have been made just before this call.
    // act_kind 1: queue act_dat at act_cyc; act_kind 2: toggle at act_cyc and act_cyc+CPB.
    task automatic run_frame(input logic [7:0] d, input int act_cyc, input int act_kind,
                             input logic [7:0] act_dat);
        logic pend_exp;
        logic [7:0] exp_cnt;
        pend_exp = 1'b0;
        for (int k = 1; k <= FLEN; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.tx !== exp_bit(d, (k-1)/CPB) || bus.in_p1[0] !== 1'b1)
                $display("FAIL frame_cycle d=%h k=%0d: tx=%b busy=%b, need tx=%b busy=1",
                         d, k, bus.tx, bus.in_p1[0], exp_bit(d, (k-1)/CPB));
            else
                n_pass++;
            n_checks++;
            if (bus.in_p1[1] !== pend_exp)
                $display("FAIL pending d=%h k=%0d: got %b, need %b", d, k, bus.in_p1[1], pend_exp);
            else
                n_pass++;
            if (act_kind == 1 && k == act_cyc) begin
                bus.out_p0 = act_dat;
                toggle();
                pend_exp = 1'b1;
            end
            if (act_kind == 2 && (k == act_cyc || k == act_cyc + CPB)) begin
                toggle();
                pend_exp = ~pend_exp;
            end
        end
        @(negedge clk);
        sent    = (sent + 1) % 256;
        exp_cnt = 8'(sent);
        n_checks++;
        if (bus.tx !== 1'b1 || bus.in_p1[0] !== 1'b0 || bus.in_p0 !== exp_cnt ||
            bus.in_p1[1] !== pend_exp || bus.in_p1[7:2] !== 6'd0)
            $display("FAIL frame_end d=%h: tx=%b in_p1=%h in_p0=%0d, need tx=1 in_p1=%h in_p0=%0d",
                     d, bus.tx, bus.in_p1, bus.in_p0, {6'd0, pend_exp, 1'b0}, exp_cnt);
        else
            n_pass++;
    endtask

    // Idle cycles: line high, not busy, counter unchanged
    task automatic check_idle(input int cycles, input string tag);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.tx !== 1'b1 || bus.in_p1 !== 8'h00 || bus.in_p0 !== 8'(sent))
                $display("FAIL %s idle k=%0d: tx=%b in_p1=%h in_p0=%0d, need tx=1 in_p1=00 in_p0=%0d",
                         tag, k, bus.tx, bus.in_p1, bus.in_p0, 8'(sent));
            else
                n_pass++;
        end
    endtask

    task automatic test_reset();
        bus.out_p0 = 8'h00;
        bus.out_p1 = 8'h00;
        go_lvl     = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.tx !== 1'b1 || bus.in_p0 !== 8'h00 || bus.in_p1 !== 8'h00)
            $display("FAIL reset_initial: tx=%b in_p0=%h in_p1=%h, need 1/00/00", bus.tx, bus.in_p0, bus.in_p1);
        else
            n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        // start a frame, then reset it mid-flight in START
        @(negedge clk);
        bus.out_p0 = 8'h5A;
        toggle();
        repeat (CPB/2 + 1) @(negedge clk);
        n_checks++;
        if (bus.tx !== 1'b0 || bus.in_p1[0] !== 1'b1)
            $display("FAIL reset_pre_start: tx=%b busy=%b, need 0/1", bus.tx, bus.in_p1[0]);
        else
            n_pass++;
        bus.out_p1 = 8'h00;
        go_lvl     = 1'b0;
        reset      = 1'b0;
        #1;
        sent = 0;
        n_checks++;
        if (bus.tx !== 1'b1 || bus.in_p0 !== 8'h00 || bus.in_p1 !== 8'h00)
            $display("FAIL reset_mid: tx=%b in_p0=%h in_p1=%h, need 1/00/00", bus.tx, bus.in_p0, bus.in_p1);
        else
            n_pass++;
        @(negedge clk);
        reset = 1'b1;
        check_idle(3*CPB, "after_reset");
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.out_p0 = 8'hA5;
        toggle();
        run_frame(8'hA5, 0, 0, 8'h00);
        check_idle(4, "single");
    endtask

    task automatic test_queued();
        @(negedge clk);
        bus.out_p0 = 8'hA5;
        toggle();
        run_frame(8'hA5, 2*CPB + 5, 1, 8'h3C);
        run_frame(8'h3C, 0, 0, 8'h00);
        check_idle(4, "queued");
    endtask

    task automatic test_cancel();
        logic [7:0] d;
        d = 8'($urandom);
        @(negedge clk);
        bus.out_p0 = d;
        toggle();
        run_frame(d, CPB + 3, 2, 8'h00);
        check_idle(2*CPB, "cancel");
    endtask

    task automatic test_abort();
        logic [7:0] d;
        @(negedge clk);
        bus.out_p0 = 8'hC3;
        toggle();
        repeat (4*CPB + CPB/2 + 1) @(negedge clk);
        n_checks++;
        if (bus.tx !== 1'b0 || bus.in_p1[0] !== 1'b1)
            $display("FAIL abort_bit3: tx=%b busy=%b, need 0/1", bus.tx, bus.in_p1[0]);
        else
            n_pass++;
        bus.out_p1 = 8'h00;
        go_lvl     = 1'b0;
        reset      = 1'b0;
        #1;
        sent = 0;
        n_checks++;
        if (bus.tx !== 1'b1 || bus.in_p0 !== 8'h00 || bus.in_p1 !== 8'h00)
            $display("FAIL abort_reset: tx=%b in_p0=%h in_p1=%h, need 1/00/00", bus.tx, bus.in_p0, bus.in_p1);
        else
            n_pass++;
        @(negedge clk);
        reset = 1'b1;
        check_idle(2*CPB, "abort");
        d = 8'($urandom);
        @(negedge clk);
        bus.out_p0 = d;
        toggle();
        run_frame(d, 0, 0, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            @(negedge clk);
            bus.out_p0 = d;
            toggle();
            run_frame(d, 0, 0, 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0, d1, d2;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        @(negedge clk);
        bus.out_p0 = d0;
        toggle();
        run_frame(d0, FLEN - 2, 1, d1);
        run_frame(d1, CPB, 1, d2);
        run_frame(d2, 0, 0, 8'h00);
        check_idle(3, "b2b");
    endtask

`ifdef PORT_TX_PARITY_EN
    task automatic test_parity();
        @(negedge clk);
        bus.out_p0 = 8'h07;
        toggle();
        run_frame(8'h07, 0, 0, 8'h00);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_queued();
        test_cancel();
        test_abort();
        test_random();
        test_back_to_back();
`ifdef PORT_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
